// File: rtl/bk_adder_seq_ctrl.sv
// Multi-precision add sequencer: one 32-bit Brent-Kung adder time-shared over NWORDS cycles, LSW first.
// Optional subtract mode (in_sub port) enabled by defining BK_SEQ_SUB_EN.
module bk_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] p0;
    logic [31:0] g;
    logic [31:0] p;

    // Prefix network as vector ops: each mask selects the nodes combined at that level.
    always_comb begin
        p0 = a ^ b;
        g  = a & b;
        g[0] = g[0] | (p0[0] & cin);
        p  = p0;
        g = g | (32'hAAAA_AAAA & p & (g << 1));  p = p & (~32'hAAAA_AAAA | (p << 1));
        g = g | (32'h8888_8888 & p & (g << 2));  p = p & (~32'h8888_8888 | (p << 2));
        g = g | (32'h8080_8080 & p & (g << 4));  p = p & (~32'h8080_8080 | (p << 4));
        g = g | (32'h8000_8000 & p & (g << 8));  p = p & (~32'h8000_8000 | (p << 8));
        g = g | (32'h8000_0000 & p & (g << 16)); p = p & (~32'h8000_0000 | (p << 16));
        g = g | (32'h0080_0000 & p & (g << 8));  p = p & (~32'h0080_0000 | (p << 8));
        g = g | (32'h0808_0800 & p & (g << 4));  p = p & (~32'h0808_0800 | (p << 4));
        g = g | (32'h2222_2220 & p & (g << 2));  p = p & (~32'h2222_2220 | (p << 2));
        g = g | (32'h5555_5554 & p & (g << 1));
        sum  = p0 ^ {g[30:0], cin};
        cout = g[31];
    end
endmodule

module bk_adder_seq_ctrl #(
    parameter int NWORDS = 4,
    localparam int W = 32 * NWORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
`ifdef BK_SEQ_SUB_EN
    input  logic         in_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         busy
);
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic [NWORDS-1:0][31:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [W-1:0]            out_sum_q, out_sum_d;
    logic                    out_cout_q, out_cout_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;
    logic [31:0]             add_sum;
    logic                    add_cout;

    bk_adder_32bit u_add (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d        = in_a;
`ifdef BK_SEQ_SUB_EN
                // Subtract as a + ~b + 1; out_cout=1 then means no borrow.
                b_d        = in_sub ? ~in_b : in_b;
                carry_d    = in_sub ? 1'b1 : in_cin;
`else
                b_d        = in_b;
                carry_d    = in_cin;
`endif
                idx_d      = '0;
                state_d    = RUN;
                in_ready_d = 1'b0;
                busy_d     = 1'b1;
            end
            RUN: begin
                sum_d[idx_q] = add_sum;
                carry_d      = add_cout;
                if (idx_q == IW'(NWORDS - 1)) begin
                    state_d     = DONE;
                    idx_d       = '0;
                    out_sum_d   = sum_d;
                    out_cout_d  = add_cout;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: if (out_ready) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign busy      = busy_q;
endmodule
